// File: rtl/circle_draw_param.sv
// circle_draw_param
// Draws a Bresenham circle outline into a SCREEN_W x SCREEN_H frame buffer,
// one pixel per clock, through the VGA adapter's x/y/colour/plot port.
// Pixels that fall off-screen are clipped: the cycle is still spent, but the
// plot strobe stays low. When mode=1, a clear pass first fills the whole
// screen with bg_colour.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               level request; accepted only in IDLE
//   mode                0 = outline only, 1 = clear screen then outline
//   centre_x/centre_y   circle centre (unsigned)
//   radius              circle radius (unsigned)
//   colour, bg_colour   outline colour and clear colour
//   done                operation finished; held until start falls
//   busy                operation in progress
//   vga_x, vga_y,       registered pixel coordinate and colour
//   vga_colour
//   vga_plot            registered write strobe that qualifies the pixel
module circle_draw_param #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int C_W      = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic [C_W-1:0] colour,
  input  logic [C_W-1:0] bg_colour,
  output logic           done,
  output logic           busy,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  // Arithmetic width: the widest operand plus a sign bit and one guard bit,
  // so that centre +/- radius and the decision variable can never overflow.
  localparam int MXY = (X_W > Y_W) ? X_W : Y_W;
  localparam int AW  = ((MXY > R_W) ? MXY : R_W) + 2;

  localparam logic signed [AW-1:0] ZERO = {AW{1'b0}};
  localparam logic signed [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] W_S  = AW'(SCREEN_W);
  localparam logic signed [AW-1:0] H_S  = AW'(SCREEN_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_INIT,
    S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6, S_OCT7,
    S_STEP, S_DONE
  } state_t;

  state_t state, state_nx;

  // Operands latched when the request is accepted, so inputs that change
  // mid-operation have no effect.
  logic [X_W-1:0] cx, cx_nx;
  logic [Y_W-1:0] cy, cy_nx;
  logic [R_W-1:0] rad, rad_nx;
  logic [C_W-1:0] col, col_nx;
  logic [C_W-1:0] bg, bg_nx;

  // Octant offsets and the Bresenham decision variable.
  logic signed [AW-1:0] ox, ox_nx, oy, oy_nx, crit, crit_nx;
  logic signed [AW-1:0] oy_inc, ox_step, rad_s;

  // Clear-pass scan position.
  logic [X_W-1:0] clr_x, clr_x_nx;
  logic [Y_W-1:0] clr_y, clr_y_nx;

  // Pixel for the state being entered next.
  logic signed [AW-1:0] px, py, cxs, cys;
  logic                 pix_on, in_range;

  assign rad_s   = $signed({{(AW-R_W){1'b0}}, rad});
  assign oy_inc  = oy + ONE;
  // x steps inward only when the midpoint lies outside the circle.
  assign ox_step = (crit <= ZERO) ? ox : (ox - ONE);

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state;
    cx_nx    = cx;
    cy_nx    = cy;
    rad_nx   = rad;
    col_nx   = col;
    bg_nx    = bg;
    ox_nx    = ox;
    oy_nx    = oy;
    crit_nx  = crit;
    clr_x_nx = clr_x;
    clr_y_nx = clr_y;
    case (state)
      S_IDLE: begin
        if (start) begin
          cx_nx    = centre_x;
          cy_nx    = centre_y;
          rad_nx   = radius;
          col_nx   = colour;
          bg_nx    = bg_colour;
          clr_x_nx = {X_W{1'b0}};
          clr_y_nx = {Y_W{1'b0}};
          state_nx = mode ? S_CLEAR : S_INIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CLEAR: begin
        // x outer, y inner scan.
        if (clr_y == Y_LAST) begin
          clr_y_nx = {Y_W{1'b0}};
          if (clr_x == X_LAST) begin
            clr_x_nx = {X_W{1'b0}};
            state_nx = S_INIT;
          end else begin
            clr_x_nx = clr_x + {{(X_W-1){1'b0}}, 1'b1};
          end
        end else begin
          clr_y_nx = clr_y + {{(Y_W-1){1'b0}}, 1'b1};
        end
      end
      S_INIT: begin
        ox_nx   = rad_s;
        oy_nx   = ZERO;
        crit_nx = ONE - rad_s;
        // oy=0 <= ox always holds, so at least one octant pass runs.
        if (ZERO <= rad_s) begin
          state_nx = S_OCT0;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6: begin
        state_nx = state_t'(state + 4'd1);
      end
      S_OCT7: begin
        state_nx = S_STEP;
      end
      S_STEP: begin
        oy_nx = oy_inc;
        ox_nx = ox_step;
        if (crit <= ZERO) begin
          crit_nx = crit + (oy_inc <<< 1) + ONE;
        end else begin
          crit_nx = crit + ((oy_inc - ox_step) <<< 1) + ONE;
        end
        if (oy_inc <= ox_step) begin
          state_nx = S_OCT0;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign cxs = $signed({{(AW-X_W){1'b0}}, cx_nx});
  assign cys = $signed({{(AW-Y_W){1'b0}}, cy_nx});

  // Pixel for the upcoming state, so the registered outputs line up with it.
  always_comb begin
    px     = ZERO;
    py     = ZERO;
    pix_on = 1'b1;
    case (state_nx)
      S_CLEAR: begin
        px = $signed({{(AW-X_W){1'b0}}, clr_x_nx});
        py = $signed({{(AW-Y_W){1'b0}}, clr_y_nx});
      end
      S_OCT0: begin px = cxs + ox_nx; py = cys + oy_nx; end
      S_OCT1: begin px = cxs + oy_nx; py = cys + ox_nx; end
      S_OCT2: begin px = cxs - oy_nx; py = cys + ox_nx; end
      S_OCT3: begin px = cxs - ox_nx; py = cys + oy_nx; end
      S_OCT4: begin px = cxs - ox_nx; py = cys - oy_nx; end
      S_OCT5: begin px = cxs - oy_nx; py = cys - ox_nx; end
      S_OCT6: begin px = cxs + oy_nx; py = cys - ox_nx; end
      S_OCT7: begin px = cxs + ox_nx; py = cys - oy_nx; end
      default: begin
        pix_on = 1'b0;
      end
    endcase
  end

  assign in_range = (px >= ZERO) && (px < W_S) && (py >= ZERO) && (py < H_S);

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cx         <= {X_W{1'b0}};
      cy         <= {Y_W{1'b0}};
      rad        <= {R_W{1'b0}};
      col        <= {C_W{1'b0}};
      bg         <= {C_W{1'b0}};
      ox         <= ZERO;
      oy         <= ZERO;
      crit       <= ZERO;
      clr_x      <= {X_W{1'b0}};
      clr_y      <= {Y_W{1'b0}};
      done       <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= {X_W{1'b0}};
      vga_y      <= {Y_W{1'b0}};
      vga_colour <= {C_W{1'b0}};
      vga_plot   <= 1'b0;
    end else begin
      state    <= state_nx;
      cx       <= cx_nx;
      cy       <= cy_nx;
      rad      <= rad_nx;
      col      <= col_nx;
      bg       <= bg_nx;
      ox       <= ox_nx;
      oy       <= oy_nx;
      crit     <= crit_nx;
      clr_x    <= clr_x_nx;
      clr_y    <= clr_y_nx;
      done     <= (state_nx == S_DONE);
      busy     <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      vga_plot <= pix_on && in_range;
      if (pix_on) begin
        // Clipped pixels still load the truncated coordinate; it is unused.
        vga_x      <= px[X_W-1:0];
        vga_y      <= py[Y_W-1:0];
        vga_colour <= (state_nx == S_CLEAR) ? bg_nx : col_nx;
      end else begin
        vga_x      <= vga_x;
        vga_y      <= vga_y;
        vga_colour <= vga_colour;
      end
    end
  end

endmodule

// File: tb/tb_circle_draw_param.sv
// Scoreboard bench for circle_draw_param: a default 160x120 instance (A) and
// a 320x240 instance (B). A Bresenham reference model pushes every expected
// on-screen pixel into a queue; monitors pop and compare on each plot strobe.
module tb_circle_draw_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       start_a, mode_a, done_a, busy_a, vp_a;
  logic [7:0] cx_a, r_a, vx_a;
  logic [6:0] cy_a, vy_a;
  logic [2:0] col_a, bg_a, vc_a;

  logic       start_b, mode_b, done_b, busy_b, vp_b;
  logic [8:0] cx_b, vx_b;
  logic [7:0] cy_b, vy_b, r_b;
  logic [2:0] col_b, bg_b, vc_b;

  circle_draw_param dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .centre_x(cx_a), .centre_y(cy_a), .radius(r_a), .colour(col_a),
    .bg_colour(bg_a), .done(done_a), .busy(busy_a), .vga_x(vx_a),
    .vga_y(vy_a), .vga_colour(vc_a), .vga_plot(vp_a)
  );

  circle_draw_param #(.SCREEN_W(320), .SCREEN_H(240), .X_W(9), .Y_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .centre_x(cx_b), .centre_y(cy_b), .radius(r_b), .colour(col_b),
    .bg_colour(bg_b), .done(done_b), .busy(busy_b), .vga_x(vx_b),
    .vga_y(vy_b), .vga_colour(vc_b), .vga_plot(vp_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] e_a, e_b;
  int lat, passes;

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return 32'((x << 16) | (y << 4) | c);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_px(input bit sel, input int x, input int y, input int c,
                         input int w, input int h);
    if (x >= 0 && x < w && y >= 0 && y < h) begin
      if (sel) exp_b.push_back(pk(x, y, c));
      else     exp_a.push_back(pk(x, y, c));
    end
  endtask

  // Reference model: clear pass (optional) then midpoint circle octants.
  task automatic model(input bit sel, input bit md, input int cx, input int cy,
                       input int r, input int col, input int bg, input int w,
                       input int h, output int np);
    int ox, oy, crit;
    if (md) begin
      for (int x = 0; x < w; x++)
        for (int y = 0; y < h; y++)
          push_px(sel, x, y, bg, w, h);
    end
    ox = r; oy = 0; crit = 1 - r; np = 0;
    do begin
      np++;
      push_px(sel, cx + ox, cy + oy, col, w, h);
      push_px(sel, cx + oy, cy + ox, col, w, h);
      push_px(sel, cx - oy, cy + ox, col, w, h);
      push_px(sel, cx - ox, cy + oy, col, w, h);
      push_px(sel, cx - ox, cy - oy, col, w, h);
      push_px(sel, cx - oy, cy - ox, col, w, h);
      push_px(sel, cx + oy, cy - ox, col, w, h);
      push_px(sel, cx + ox, cy - oy, col, w, h);
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin ox--; crit += 2 * (oy - ox) + 1; end
    end while (oy <= ox);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy_done_excl_a", {31'd0, busy_a & done_a}, 32'd0);
      if (vp_a === 1'b1) begin
        check_eq("busy_at_plot_a", {31'd0, busy_a}, 32'd1);
        if (exp_a.size() == 0) check_eq("extra_plot_a", pk(vx_a, vy_a, vc_a), 32'hFFFF_FFFF);
        else begin
          e_a = exp_a.pop_front();
          check_eq("pixel_a", pk(vx_a, vy_a, vc_a), e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy_done_excl_b", {31'd0, busy_b & done_b}, 32'd0);
      if (vp_b === 1'b1) begin
        if (exp_b.size() == 0) check_eq("extra_plot_b", pk(vx_b, vy_b, vc_b), 32'hFFFF_FFFF);
        else begin
          e_b = exp_b.pop_front();
          check_eq("pixel_b", pk(vx_b, vy_b, vc_b), e_b);
        end
      end
    end
  end

  // Runs one operation on A. Latency is counted from the cycle in which start
  // is sampled, so a radius-0 outline reports 11.
  task automatic run_a(input bit md, input int cx, input int cy, input int r,
                       input int col, input int bg);
    int np, cyc;
    model(1'b0, md, cx, cy, r, col, bg, 160, 120, np);
    @(negedge clk);
    mode_a = md; cx_a = 8'(cx); cy_a = 7'(cy); r_a = 8'(r);
    col_a = 3'(col); bg_a = 3'(bg); start_a = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs; the latched copies must be used.
    mode_a = ~md; cx_a = 8'd7; cy_a = 7'd3; r_a = 8'd2; col_a = 3'd7; bg_a = 3'd6;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 40000) begin @(posedge clk); #1; cyc++; end
    check_eq("done_seen_a", {31'd0, done_a}, 32'd1);
    check_eq("latency_a", 32'(cyc), 32'((md ? 19200 : 0) + 2 + 9 * np));
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_held_a", {31'd0, done_a}, 32'd1);
    check_eq("busy_in_done_a", {31'd0, busy_a}, 32'd0);
    check_eq("queue_left_a", 32'(exp_a.size()), 32'd0);
    @(negedge clk); start_a = 1'b0;
    @(posedge clk); #1;
    check_eq("done_drop_a", {31'd0, done_a}, 32'd0);
    check_eq("idle_busy_a", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; cx_a = 8'd0; cy_a = 7'd0; r_a = 8'd0; col_a = 3'd0; bg_a = 3'd0;
    start_b = 1'b0; mode_b = 1'b0; cx_b = 9'd0; cy_b = 8'd0; r_b = 8'd0; col_b = 3'd0; bg_b = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs_a", {19'd0, done_a, busy_a, vp_a, vx_a | {1'b0, vy_a} | {5'd0, vc_a}}, 32'd0);
    check_eq("rst_outputs_b", {19'd0, done_b, busy_b, vp_b, vx_b | {1'b0, vy_b} | {6'd0, vc_b}}, 32'd0);
    @(negedge clk); rst = 1'b0; mon_en = 1'b1;

    // Radius 0: eight coincident plots, latency 11.
    run_a(1'b0, 5, 5, 0, 4, 0);
    // Centre (80,60) radius 40 colour 2.
    run_a(1'b0, 80, 60, 40, 2, 0);
    // Clipping at the corner.
    run_a(1'b0, 0, 0, 10, 1, 0);

    // Reset in the middle of a draw, while in OCT3.
    model(1'b0, 1'b0, 80, 60, 40, 3, 0, 160, 120, passes);
    @(negedge clk);
    mode_a = 1'b0; cx_a = 8'd80; cy_a = 7'd60; r_a = 8'd40; col_a = 3'd3; start_a = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_eq("oct3_pixel", pk(vx_a, vy_a, vc_a), pk(40, 60, 3));
    @(negedge clk); rst = 1'b1; start_a = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_outputs", {19'd0, done_a, busy_a, vp_a, vx_a | {1'b0, vy_a} | {5'd0, vc_a}}, 32'd0);
    exp_a.delete();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_idle", {30'd0, busy_a, vp_a}, 32'd0);
    run_a(1'b0, 80, 60, 40, 3, 0);

    // Clear pass then outline.
    run_a(1'b1, 80, 60, 20, 5, 0);

    // Larger screen: right and bottom clipped.
    model(1'b1, 1'b0, 300, 200, 50, 6, 0, 320, 240, passes);
    @(negedge clk);
    cx_b = 9'd300; cy_b = 8'd200; r_b = 8'd50; col_b = 3'd6; start_b = 1'b1;
    @(posedge clk); #1;
    cx_b = 9'd1;
    lat = 1;
    while (done_b !== 1'b1 && lat < 40000) begin @(posedge clk); #1; lat++; end
    check_eq("done_seen_b", {31'd0, done_b}, 32'd1);
    check_eq("latency_b", 32'(lat), 32'(2 + 9 * passes));
    check_eq("queue_left_b", 32'(exp_b.size()), 32'd0);
    @(negedge clk); start_b = 1'b0;
    @(posedge clk); #1;
    check_eq("done_drop_b", {31'd0, done_b}, 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
